nn_frame_feeder: RTL and testbench
==================================

// Module: nn_frame_feeder
// PURPOSE
//  Ping-pong image buffer between the camera preprocessing chain and N HLS-generated NN lanes.
//  Accepts one preprocessed frame (gray or binarized) into the write bank while lanes read the other.
//  On frame end it swaps banks, pulses ap_start to all lanes, collects each lane's predict result
//  and publishes all results together. Frames arriving while lanes are busy are dropped and counted.
// PARAMETERS
//  PIX_W    8      pixel width in bits
//  ADDR_W   10     pixel address width; bank depth = 2**ADDR_W
//  N_LANES  1      number of NN lanes; each has its own read port
//  RES_W    32     width of one lane's predict result
//  TIMEOUT  2**20  max RUN cycles before abort; must be >= 2
// PORTS
//  CLK          in   1               clock
//  RST          in   1               synchronous, active-high reset
//  s_pix_data   in   PIX_W           pixel value
//  s_pix_addr   in   ADDR_W          pixel address within frame
//  s_pix_en     in   1               write strobe
//  s_frame_end  in   1               one-cycle pulse: current frame complete
//  cfg_bin      in   1               1: store {PIX_W{pix>cfg_thresh}}; 0: store pix
//  cfg_thresh   in   PIX_W           binarize threshold (unsigned compare, strict >)
//  cfg_run      in   1               1: lanes are started on frame end; 0: frames buffered only
//  nn_start     out  N_LANES         per-lane ap_start
//  nn_idle      in   N_LANES         per-lane ap_idle
//  nn_raddr     in   N_LANES*ADDR_W  per-lane read address (lane i at [i*ADDR_W +: ADDR_W])
//  nn_rdata     out  N_LANES*PIX_W   per-lane read data from read bank
//  nn_res       in   N_LANES*RES_W   per-lane predict result
//  nn_res_vld   in   N_LANES         per-lane result valid (ap_vld)
//  res_data     out  N_LANES*RES_W   latched results of last completed run
//  res_valid    out  1               one-cycle pulse: res_data updated
//  res_timeout  out  1               sticky-per-run: last run aborted by TIMEOUT
//  busy         out  1               FSM not in IDLE
//  frame_cnt    out  16              frames accepted (wraps 0xFFFF->0)
//  drop_cnt     out  16              frames dropped (saturates at 0xFFFF)
// BEHAVIOUR
//  Reset: all outputs 0; wbank=0; FSM=IDLE; done flags cleared. Memory contents not reset.
//  Write: s_pix_en writes cfg_bin/cfg_thresh-converted data to bank wbank at s_pix_addr, 1 cycle.
//  Read: nn_rdata[i] = bank(~wbank)[nn_raddr[i]], registered, latency 1 (HLS q0 timing).
//  Pixel write and s_frame_end in the same cycle: pixel goes to the old wbank before swap.
//  FSM IDLE: on s_frame_end: wbank<=~wbank, frame_cnt++; if cfg_run -> START, else stay IDLE.
//  FSM START: wait until &nn_idle; then nn_start=all-ones for exactly 1 cycle, clear done
//    flags and timer -> RUN. (nn_start never asserted while any lane non-idle.)
//  FSM RUN: nn_res_vld[i] latches nn_res[i] into res_data[i] and sets done[i]; later vld on
//    a done lane overwrites data. When all done -> DONE. Timer increments each RUN cycle;
//    timer==TIMEOUT-1 with lanes outstanding -> DONE with timeout flag set.
//  FSM DONE: res_valid=1 for 1 cycle, res_timeout<=flag -> IDLE. Undone lanes keep old res_data.
//  s_frame_end in START/RUN/DONE: no swap, frame_cnt unchanged, drop_cnt++ (saturating);
//    write bank keeps receiving pixels (next frame overwrites it).
//  cfg_run dropped to 0 mid-run: current run completes normally.
//  RST mid-run: immediate return to IDLE, nn_start=0, results and counters cleared.
//  busy=1 in START, RUN, DONE.
// TESTING
//  1. N_LANES=2: write addr k=k&0xFF, frame_end, cfg_run=1, idle=11 -> one nn_start=11 pulse; lane
//     reading addr 5 gets 0x05 next cycle; vld both with 0x7,0x3 -> res_valid 1 cycle, res_data={3,7}.
//  2. cfg_bin=1, thresh=0x80: pixels 0x80,0x81 -> stored 0x00,0xFF; read back after swap.
//  3. Second frame_end during RUN -> drop_cnt=1, frame_cnt=1, no swap, nn_start stays 0.
//  4. TIMEOUT=16, lane1 never vld -> DONE after 16 RUN cycles, res_timeout=1, res_data[1] unchanged.
//  5. cfg_run=0, 3 frame_ends -> frame_cnt=3, wbank toggles 3x, nn_start never asserted, busy=0.
//  6. RST asserted during RUN -> next cycle busy=0, nn_start=0, counters 0, res_valid never pulses.

Source files
------------

// File: rtl/nn_frame_feeder.sv
// Ping-pong pixel buffer feeding N NN lanes: one bank is written by the camera chain while
// the lanes read the other, with per-run start/collect/publish control and drop accounting.
module nn_frame_feeder #(
  parameter int PIX_W   = 8,
  parameter int ADDR_W  = 10,
  parameter int N_LANES = 1,
  parameter int RES_W   = 32,
  parameter int TIMEOUT = 2**20
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [PIX_W-1:0]           s_pix_data,
  input  logic [ADDR_W-1:0]          s_pix_addr,
  input  logic                       s_pix_en,
  input  logic                       s_frame_end,
  input  logic                       cfg_bin,
  input  logic [PIX_W-1:0]           cfg_thresh,
  input  logic                       cfg_run,
  output logic [N_LANES-1:0]         nn_start,
  input  logic [N_LANES-1:0]         nn_idle,
  input  logic [N_LANES*ADDR_W-1:0]  nn_raddr,
  output logic [N_LANES*PIX_W-1:0]   nn_rdata,
  input  logic [N_LANES*RES_W-1:0]   nn_res,
  input  logic [N_LANES-1:0]         nn_res_vld,
  output logic [N_LANES*RES_W-1:0]   res_data,
  output logic                       res_valid,
  output logic                       res_timeout,
  output logic                       busy,
  output logic [15:0]                frame_cnt,
  output logic [15:0]                drop_cnt
);

  localparam int          DEPTH = 2**ADDR_W;
  localparam logic [31:0] T_MAX = 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_DONE} state_t;

  state_t                     state_q;
  logic                       wbank_q;
  logic [N_LANES-1:0]         nn_start_q;
  logic [N_LANES-1:0]         done_q;
  logic [N_LANES-1:0]         done_d;
  logic [31:0]                timer_q;
  logic [N_LANES*RES_W-1:0]   res_data_q;
  logic                       res_valid_q;
  logic                       res_timeout_q;
  logic [15:0]                frame_cnt_q;
  logic [15:0]                drop_cnt_q;
  logic [PIX_W-1:0]           pix_wr_d;

  assign pix_wr_d = cfg_bin ? {PIX_W{s_pix_data > cfg_thresh}} : s_pix_data;
  assign done_d   = done_q | nn_res_vld;

  // Each lane owns a private copy of both banks so every read port maps to its own RAM.
  genvar gi;
  generate
    for (gi = 0; gi < N_LANES; gi++) begin : g_lane
      logic [PIX_W-1:0] mem_q [0:2*DEPTH-1];
      logic [PIX_W-1:0] rdata_q;

      always_ff @(posedge CLK) begin
        if (s_pix_en) begin
          mem_q[{wbank_q, s_pix_addr}] <= pix_wr_d;
        end
      end

      always_ff @(posedge CLK) begin
        if (RST) begin
          rdata_q <= '0;
        end else begin
          rdata_q <= mem_q[{~wbank_q, nn_raddr[gi*ADDR_W +: ADDR_W]}];
        end
      end

      assign nn_rdata[gi*PIX_W +: PIX_W] = rdata_q;
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= S_IDLE;
      wbank_q       <= 1'b0;
      nn_start_q    <= '0;
      done_q        <= '0;
      timer_q       <= '0;
      res_data_q    <= '0;
      res_valid_q   <= 1'b0;
      res_timeout_q <= 1'b0;
      frame_cnt_q   <= '0;
      drop_cnt_q    <= '0;
    end else begin
      nn_start_q  <= '0;
      res_valid_q <= 1'b0;

      // Frames only swap in while idle; anything else is a drop and its pixels get overwritten.
      if (s_frame_end) begin
        if (state_q == S_IDLE) begin
          wbank_q     <= ~wbank_q;
          frame_cnt_q <= frame_cnt_q + 16'd1;
        end else if (drop_cnt_q != 16'hFFFF) begin
          drop_cnt_q <= drop_cnt_q + 16'd1;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (s_frame_end && cfg_run) begin
            state_q <= S_START;
          end
        end
        S_START: begin
          if (&nn_idle) begin
            nn_start_q <= '1;
            done_q     <= '0;
            timer_q    <= '0;
            state_q    <= S_RUN;
          end
        end
        S_RUN: begin
          for (int i = 0; i < N_LANES; i++) begin
            if (nn_res_vld[i]) begin
              res_data_q[i*RES_W +: RES_W] <= nn_res[i*RES_W +: RES_W];
            end
          end
          done_q  <= done_d;
          timer_q <= timer_q + 32'd1;
          if (&done_d) begin
            res_valid_q   <= 1'b1;
            res_timeout_q <= 1'b0;
            state_q       <= S_DONE;
          end else if (timer_q == T_MAX) begin
            res_valid_q   <= 1'b1;
            res_timeout_q <= 1'b1;
            state_q       <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign nn_start    = nn_start_q;
  assign res_data    = res_data_q;
  assign res_valid   = res_valid_q;
  assign res_timeout = res_timeout_q;
  assign busy        = (state_q != S_IDLE);
  assign frame_cnt   = frame_cnt_q;
  assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_nn_frame_feeder.sv
// Directed-plus-random bench for nn_frame_feeder with a two-bank array model of the buffer.
module tb_nn_frame_feeder;

  localparam int PIX_W   = 8;
  localparam int ADDR_W  = 8;
  localparam int N_LANES = 2;
  localparam int RES_W   = 32;
  localparam int TIMEOUT = 16;

  logic                      CLK = 1'b0;
  logic                      RST;
  logic [PIX_W-1:0]          s_pix_data;
  logic [ADDR_W-1:0]         s_pix_addr;
  logic                      s_pix_en;
  logic                      s_frame_end;
  logic                      cfg_bin;
  logic [PIX_W-1:0]          cfg_thresh;
  logic                      cfg_run;
  logic [N_LANES-1:0]        nn_start;
  logic [N_LANES-1:0]        nn_idle;
  logic [N_LANES*ADDR_W-1:0] nn_raddr;
  logic [N_LANES*PIX_W-1:0]  nn_rdata;
  logic [N_LANES*RES_W-1:0]  nn_res;
  logic [N_LANES-1:0]        nn_res_vld;
  logic [N_LANES*RES_W-1:0]  res_data;
  logic                      res_valid;
  logic                      res_timeout;
  logic                      busy;
  logic [15:0]               frame_cnt;
  logic [15:0]               drop_cnt;

  nn_frame_feeder #(
    .PIX_W(PIX_W), .ADDR_W(ADDR_W), .N_LANES(N_LANES), .RES_W(RES_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK), .RST(RST),
    .s_pix_data(s_pix_data), .s_pix_addr(s_pix_addr), .s_pix_en(s_pix_en),
    .s_frame_end(s_frame_end), .cfg_bin(cfg_bin), .cfg_thresh(cfg_thresh), .cfg_run(cfg_run),
    .nn_start(nn_start), .nn_idle(nn_idle), .nn_raddr(nn_raddr), .nn_rdata(nn_rdata),
    .nn_res(nn_res), .nn_res_vld(nn_res_vld), .res_data(res_data), .res_valid(res_valid),
    .res_timeout(res_timeout), .busy(busy), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;
  int start_pulses = 0;
  int valid_pulses = 0;

  // Reference model: two banks, current write bank index, counters.
  logic [PIX_W-1:0] mbank [2][256];
  int mw = 0;
  int mframe = 0;
  int mdrop = 0;

  always @(negedge CLK) begin
    if (nn_start != '0) start_pulses++;
    if (res_valid === 1'b1) valid_pulses++;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PIX_W-1:0] conv(input logic [PIX_W-1:0] d);
    if (cfg_bin) return (d > cfg_thresh) ? 8'hFF : 8'h00;
    return d;
  endfunction

  // Drive one pixel, optionally together with a frame_end; model applies write before swap.
  task automatic pix(input logic [7:0] a, input logic [7:0] d, input bit fe, input bit accept);
    s_pix_en = 1'b1; s_pix_addr = a; s_pix_data = d; s_frame_end = fe;
    mbank[mw][a] = conv(d);
    if (fe) begin
      if (accept) begin mw = 1 - mw; mframe++; end
      else mdrop++;
    end
    tick();
    s_pix_en = 1'b0; s_frame_end = 1'b0;
  endtask

  task automatic fe(input bit accept);
    s_frame_end = 1'b1;
    if (accept) begin mw = 1 - mw; mframe++; end
    else mdrop++;
    tick();
    s_frame_end = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a0, input logic [7:0] a1);
    nn_raddr = {a1, a0};
    tick();
    chk("rdata_lane0", nn_rdata[7:0], mbank[1-mw][a0]);
    chk("rdata_lane1", nn_rdata[15:8], mbank[1-mw][a1]);
  endtask

  initial begin
    logic [7:0] a, d, r;
    int n;

    RST = 1'b1; s_pix_data = '0; s_pix_addr = '0; s_pix_en = 1'b0; s_frame_end = 1'b0;
    cfg_bin = 1'b0; cfg_thresh = '0; cfg_run = 1'b0; nn_idle = 2'b11; nn_raddr = '0;
    nn_res = '0; nn_res_vld = '0;
    repeat (3) tick();
    RST = 1'b0;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_start", nn_start, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_timeout", res_timeout, 0);

    // Ramp frame, start gated on idle, lane read latency, both results collected.
    cfg_run = 1'b1;
    for (int k = 0; k < 256; k++) pix(8'(k), 8'(k), 1'b0, 1'b0);
    fe(1'b1);
    chk("s1_frame_cnt", frame_cnt, 16'(mframe));
    chk("s1_busy", busy, 1);
    nn_idle = 2'b01;
    repeat (3) tick();
    chk("s1_start_gated", start_pulses, 0);
    nn_idle = 2'b11;
    tick();
    chk("s1_start", nn_start, 2'b11);
    nn_idle = 2'b00;
    r = 8'($urandom_range(0, 255));
    nn_raddr = {r, 8'd5};
    tick();
    chk("s1_start_pulse_len", nn_start, 0);
    chk("s1_rd_addr5", nn_rdata[7:0], 8'h05);
    chk("s1_rd_lane1", nn_rdata[15:8], r);
    for (int k = 0; k < 6; k++) rd(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    nn_res = {32'h3, 32'h7}; nn_res_vld = 2'b11;
    tick();
    nn_res_vld = 2'b00;
    chk("s1_res_valid", res_valid, 1);
    chk("s1_res_data", res_data, {32'h3, 32'h7});
    chk("s1_res_timeout", res_timeout, 0);
    tick();
    chk("s1_res_valid_len", res_valid, 0);
    chk("s1_busy_end", busy, 0);
    nn_idle = 2'b11;

    // Binarization at the threshold boundary, buffer-only frame.
    cfg_bin = 1'b1; cfg_thresh = 8'h80; cfg_run = 1'b0;
    for (int k = 0; k < 20; k++) pix(8'($urandom_range(0, 255)), 8'($urandom), 1'b0, 1'b0);
    pix(8'd10, 8'h80, 1'b0, 1'b0);
    pix(8'd11, 8'h81, 1'b0, 1'b0);
    fe(1'b1);
    chk("s2_busy", busy, 0);
    chk("s2_frame_cnt", frame_cnt, 16'(mframe));
    rd(8'd10, 8'd11);
    chk("s2_bin_eq", nn_rdata[7:0], 8'h00);
    chk("s2_bin_gt", nn_rdata[15:8], 8'hFF);
    for (int k = 0; k < 6; k++) rd(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));

    // Random frame, drop during RUN, lane1 silent -> timeout.
    cfg_bin = 1'b0; cfg_run = 1'b1;
    for (int k = 0; k < 256; k++) pix(8'(k), 8'($urandom), 1'b0, 1'b0);
    fe(1'b1);
    tick();
    chk("s3_start", nn_start, 2'b11);
    nn_idle = 2'b00;
    d = 8'($urandom);
    pix(8'd20, d, 1'b1, 1'b0);
    n = 1;
    chk("s3_drop_cnt", drop_cnt, 16'(mdrop));
    chk("s3_frame_cnt", frame_cnt, 16'(mframe));
    chk("s3_no_restart", nn_start, 0);
    nn_res = {32'hDEADBEEF, 32'hAAAA}; nn_res_vld = 2'b01;
    tick();
    n = 2;
    nn_res_vld = 2'b00;
    while (res_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("s3_timeout_cycles", n, TIMEOUT);
    chk("s3_res_timeout", res_timeout, 1);
    chk("s3_res_data", res_data, {32'h3, 32'hAAAA});
    tick();
    chk("s3_busy_end", busy, 0);
    for (int k = 0; k < 4; k++) rd(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    nn_idle = 2'b11;

    // Buffer-only frames: bank toggles each time, including write coincident with frame_end.
    cfg_run = 1'b0;
    for (int f = 0; f < 3; f++) begin
      a = 8'($urandom_range(21, 255));
      d = 8'($urandom);
      if (f == 1) pix(a, d, 1'b1, 1'b1);
      else begin
        pix(a, d, 1'b0, 1'b0);
        fe(1'b1);
      end
      chk("s4_busy", busy, 0);
      rd(a, (f == 0) ? 8'd20 : 8'($urandom_range(0, 255)));
    end
    chk("s4_frame_cnt", frame_cnt, 16'(mframe));
    chk("s4_start_pulses", start_pulses, 2);

    // Reset in the middle of a run.
    cfg_run = 1'b1;
    fe(1'b1);
    tick();
    chk("s5_start", nn_start, 2'b11);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    mw = 0; mframe = 0; mdrop = 0;
    chk("s5_busy", busy, 0);
    chk("s5_start_clr", nn_start, 0);
    chk("s5_frame_cnt", frame_cnt, 0);
    chk("s5_drop_cnt", drop_cnt, 0);
    chk("s5_res_data", res_data, 0);
    chk("s5_res_timeout", res_timeout, 0);
    nn_res = {32'($urandom), 32'($urandom)}; nn_res_vld = 2'b11;
    repeat (20) tick();
    nn_res_vld = 2'b00;
    chk("s5_no_res_valid", valid_pulses, 2);
    chk("s5_busy_idle", busy, 0);
    cfg_run = 1'b0;
    d = 8'($urandom);
    pix(8'd30, d, 1'b0, 1'b0);
    fe(1'b1);
    rd(8'd30, 8'd31);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
